// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its prefetch queue.
package fetch_pkg;

  localparam int OPCODE_WIDTH = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } fetch_state_e;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   pc;
  } fetch_entry_t;

  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc & ~ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// Small FIFO of {opcode, pc} entries with flush; head is read combinationally from the
// register array so a write is visible on the output the cycle after it lands.
module opcode_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;
  logic [DEPTH-1:0] w_we;

  // A push into a full queue is still legal when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_do_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign w_we[gi] = w_do_push && (r_wr_ptr == PW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= i_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch sequencer: drives the opcode buffer one word at a time, queues completed opcodes
// with their PC, and flushes/restarts on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_WIDTH-1:0]   ip,
  output logic                    startLoading,
  input  logic                    busy,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [ADDR_WIDTH-1:0]   out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_IP = align_pc(RESET_PC);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_ip;
  logic                  r_discard;
  logic                  w_issue;
  logic                  w_complete;
  logic                  w_start;
  logic                  w_push;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  fetch_entry_t          w_head;
  fetch_entry_t          w_entry;

  // Nothing is in flight while IDLE, so free slots reduce to DEPTH - count there.
  // A redirect seen in IDLE holds off the issue so the next request carries the new PC.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_count < CW'(DEPTH)) && !redirect) begin
          w_issue      = 1'b1;
          w_start      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_start = 1'b1;
        if (busy) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_start = 1'b1;
        if (!busy) begin
          w_complete   = 1'b1;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_IP;
      r_ip       <= RESET_IP;
      r_discard  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_ip <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc <= align_pc(redirect_pc);
      end else if (w_complete && !r_discard) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      // The buffer cannot abort, so a redirected fetch runs out and its result is dropped.
      if (r_state == ST_GAP) begin
        r_discard <= 1'b0;
      end else if (redirect && ((r_state == ST_ISSUE) || (r_state == ST_WAIT))) begin
        r_discard <= 1'b1;
      end
    end
  end

  assign w_push       = w_complete && !r_discard && !redirect;
  assign w_entry      = '{opcode: opcode, pc: r_ip};
  assign startLoading = w_start && !reset;
  assign ip           = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ? r_ip : r_fetch_pc;

  opcode_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (out_valid && out_ready),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign out_valid  = !w_empty;
  assign out_opcode = w_head.opcode;
  assign out_pc     = w_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural opcode buffer answers fetches, and tables of
// expected {pc, opcode} pops are checked in order, plus reset/redirect corner sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ip;
  logic        startLoading;
  logic        busy;
  logic [31:0] opcode;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_opcode;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ip           (ip),
    .startLoading (startLoading),
    .busy         (busy),
    .opcode       (opcode),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_pc       (out_pc)
  );

  typedef struct {
    logic [31:0] exp_pc;
    logic [31:0] exp_op;
    int          hold;
  } vec_t;

  vec_t vecs [15];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   guard;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1111_1111;
      32'h0000_0004: return 32'h2222_2222;
      32'h0000_0008: return 32'h3333_3333;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Opcode buffer model: acts just after the falling edge on the values the DUT presents
  // at the next rising edge; busy rises one cycle after the request and falls m_lat later.
  int          m_lat = 2;
  int          m_cnt;
  logic        m_armed;
  logic        m_pend;
  logic [31:0] m_addr;
  initial begin
    busy = 1'b0; opcode = 32'h0; m_cnt = 0; m_armed = 1'b1; m_pend = 1'b0; m_addr = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        busy = 1'b0; m_cnt = 0; m_armed = 1'b1; m_pend = 1'b0;
      end else begin
        if (m_cnt != 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            busy   = 1'b0;
            opcode = mem_word(m_addr);
          end
        end else if (m_pend) begin
          m_pend = 1'b0; busy = 1'b1; m_cnt = m_lat;
        end else if (m_armed && startLoading) begin
          m_pend = 1'b1; m_armed = 1'b0; m_addr = ip;
        end
        if (!startLoading && m_cnt == 0 && !m_pend) m_armed = 1'b1;
      end
    end
  end

  // Issue monitor: counts startLoading rising edges and the low-run length between them.
  int          issue_cnt;
  logic [31:0] last_ip;
  int          low_run;
  int          gap_min;
  int          gap_max;
  logic        prev_sl;
  logic        seen_issue;
  initial begin
    issue_cnt = 0; last_ip = 32'h0; low_run = 0; prev_sl = 1'b0; seen_issue = 1'b0;
    gap_min = 1000; gap_max = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        issue_cnt = 0; prev_sl = 1'b0; low_run = 0; seen_issue = 1'b0;
      end else begin
        if (startLoading && !prev_sl) begin
          issue_cnt++;
          last_ip = ip;
          $display("[TB] issue #%0d ip=%08h", issue_cnt, ip);
          if (seen_issue) begin
            if (low_run < gap_min) gap_min = low_run;
            if (low_run > gap_max) gap_max = low_run;
          end
          seen_issue = 1'b1;
        end
        if (!startLoading) low_run++;
        else low_run = 0;
        prev_sl = startLoading;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int g;
    for (int i = lo; i <= hi; i++) begin
      g = 0;
      while (!out_valid && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (!out_valid) begin
        timeout($sformatf("vec%0d_valid", i));
      end else begin
        check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_op", i), out_opcode, vecs[i].exp_op);
        for (int h = 0; h < vecs[i].hold; h++) begin
          @(negedge clk);
          check($sformatf("vec%0d_hold%0d_valid", i, h), {31'b0, out_valid}, 32'h1);
          check($sformatf("vec%0d_hold%0d_pc", i, h), out_pc, vecs[i].exp_pc);
        end
        $display("[TB] pop vec%0d pc=%08h op=%08h", i, out_pc, out_opcode);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    gap_min = 1000; gap_max = 0;
  endtask

  task automatic wait_issue_busy(input int n, input string name);
    int g;
    g = 0;
    while (!(issue_cnt == n && busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!(issue_cnt == n && busy)) timeout(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ip"},    ip,                     32'h0);
    check({tag, "_start"}, {31'b0, startLoading},  32'h0);
    check({tag, "_valid"}, {31'b0, out_valid},     32'h0);
    check({tag, "_op"},    out_opcode,             32'h0);
    check({tag, "_pc"},    out_pc,                 32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0000, 32'h1111_1111, 0};
    vecs[1]  = '{32'h0000_0004, 32'h2222_2222, 2};
    vecs[2]  = '{32'h0000_0008, 32'h3333_3333, 0};
    vecs[3]  = '{32'h0000_0000, 32'h1111_1111, 0};
    vecs[4]  = '{32'h0000_0004, 32'h2222_2222, 0};
    vecs[5]  = '{32'h0000_0008, 32'h3333_3333, 0};
    vecs[6]  = '{32'h0000_000C, 32'hA5A5_A5A9, 0};
    vecs[7]  = '{32'h0000_0010, 32'hA5A5_A5B5, 0};
    vecs[8]  = '{32'h0000_0100, 32'hA5A5_A4A5, 0};
    vecs[9]  = '{32'h0000_0104, 32'hA5A5_A4A1, 1};
    vecs[10] = '{32'h0000_0200, 32'hA5A5_A7A5, 0};
    vecs[11] = '{32'hFFFF_FFF8, 32'h5A5A_5A5D, 0};
    vecs[12] = '{32'hFFFF_FFFC, 32'h5A5A_5A59, 0};
    vecs[13] = '{32'h0000_0000, 32'h1111_1111, 0};
    vecs[14] = '{32'h0000_0000, 32'h1111_1111, 0};

    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // In-order stream with one-cycle re-arm gap between fetches.
    reset = 1'b0;
    gap_min = 1000; gap_max = 0;
    run_vecs(0, 2);
    check("gap_min", gap_min, 32'd1);
    check("gap_max", gap_max, 32'd1);

    // Back-pressure: queue fills with exactly DEPTH fetches, then resumes after a pop.
    do_reset();
    repeat (60) @(negedge clk);
    check("full_issues", issue_cnt, 32'd4);
    check("full_last_ip", last_ip, 32'h0000_000C);
    check("full_start", {31'b0, startLoading}, 32'h0);
    check("full_valid", {31'b0, out_valid}, 32'h1);
    run_vecs(3, 3);
    guard = 0;
    while (issue_cnt < 5 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (issue_cnt < 5) timeout("refill_issue");
    check("refill_ip", last_ip, 32'h0000_0010);
    run_vecs(4, 7);

    // Redirect while waiting on pc 8: queued and in-flight opcodes are dropped.
    m_lat = 3;
    do_reset();
    wait_issue_busy(3, "s3_wait");
    check("s3_ip", ip, 32'h0000_0008);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    check("s3_flush_valid", {31'b0, out_valid}, 32'h0);
    check("s3_ip_stable", ip, 32'h0000_0008);
    run_vecs(8, 9);

    // Redirect in the same cycle as a completion and a pop, with two entries queued.
    m_lat = 2;
    do_reset();
    wait_issue_busy(3, "s4_wait");
    #3;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check("s4_pre_valid", {31'b0, out_valid}, 32'h1);
    check("s4_pre_start", {31'b0, startLoading}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b0;
    check("s4_flush_valid", {31'b0, out_valid}, 32'h0);
    guard = 0;
    while (issue_cnt < 4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (issue_cnt < 4) timeout("s4_issue");
    check("s4_issue_ip", last_ip, 32'h0000_0200);
    run_vecs(10, 10);

    // PC wrap at the top of the address space.
    do_reset();
    wait_issue_busy(1, "s5_wait");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    run_vecs(11, 13);

    // Asynchronous reset in the middle of a fetch.
    do_reset();
    wait_issue_busy(2, "s6_wait");
    check("s6_pre_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check_reset_outputs("s6_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_vecs(14, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch sequencer and prefetch queue sitting directly downstream of the word opcode buffer. Generates the word-aligned fetch address and start strobe for the buffer, collects each completed 32-bit opcode with its PC into a small FIFO, and presents them to the decoder over a valid/ready handshake. Supports a redirect input (branch/jump) that flushes queued and in-flight opcodes and restarts fetching at a new PC.

## Interface
- DEPTH, 4, queue entries (power of two, 2..16)
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] ignored)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- ip  out  32  fetch address to opcode buffer, word aligned
- startLoading  out  1  fetch request to opcode buffer
- busy  in  1  opcode buffer busy
- opcode  in  32  opcode from buffer, valid in completion cycle
- redirect  in  1  flush and restart fetching (one-cycle pulse)
- redirect_pc  in  32  new fetch PC, bits [1:0] forced to 0
- out_valid  out  1  queue head valid
- out_ready  in  1  decoder accepts head
- out_opcode  out  32  head opcode
- out_pc  out  32  head PC

## Operation
- Fetch FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE: if free slots (DEPTH − count − inflight) > 0 → ISSUE, drive ip=fetch_pc, startLoading=1.
- ISSUE: startLoading=1, ip stable; on busy=1 → WAIT.
- WAIT: startLoading=1, ip stable; completion = busy 1→0 (busy=0 in WAIT) → latch opcode; if not discard, push {opcode, ip}; fetch_pc += 4; → GAP.
- GAP: startLoading=0 for exactly one cycle (re-arms buffer) → IDLE.
- inflight = 1 in ISSUE/WAIT, else 0; fetch never issued when it could overflow the queue.
- fetch_pc wraps 32'hFFFF_FFFC → 0.
- Pop: out_valid & out_ready removes head; simultaneous push and pop allowed at any count.
- Redirect: queue emptied next cycle; fetch_pc = {redirect_pc[31:2],2'b00}; if FSM in ISSUE/WAIT, set discard flag — current fetch runs to completion (buffer has no abort), result dropped, flag cleared in GAP, fetch_pc not incremented.
- Redirect same cycle as completion: completion dropped. Redirect same cycle as pop: flush wins.
- Redirect in IDLE/GAP: next issue uses redirect_pc.

## Timing
- Reset values: ip=RESET_PC&~3, startLoading=0, out_valid=0, out_opcode=0, out_pc=0, FSM=IDLE, count=0, discard=0.
- First startLoading=1 on first clk edge after reset release.
- Opcode visible on out_* the cycle after completion cycle (registered FIFO write); empty→valid latency 1.
- Minimum fetch period: ISSUE(≥1)+WAIT(≥1)+GAP(1) cycles plus buffer latency.
- out_opcode/out_pc stable while out_valid=1 and out_ready=0.
- Reset mid-fetch: all state cleared asynchronously; opcode buffer is reset concurrently, no completion expected.
- busy high at reset release or in IDLE: ignored.

## Structure
- Package fetch_pkg: FSM state enum, OPCODE_WIDTH=32, ADDR_WIDTH=32, PC_STEP=4, fetch-entry struct {opcode, pc}.
- Sub-module opcode_fifo: synchronous FIFO of fetch entries, DEPTH parameter, push/pop/flush, count output, wrap-around pointers, async reset.
- Top holds FSM, fetch_pc, discard flag.

## Test plan
- Reset, RESET_PC=0, out_ready=1, memory words 0,4,8 = 11111111/22222222/33333333 → out_pc 0,4,8 in order with matching opcodes, startLoading low one cycle between fetches.
- out_ready=0, DEPTH=4 → exactly 4 fetches (pc 0..C), no 5th startLoading; raise out_ready → pc 10 fetched after first pop.
- Redirect to 32'h0000_0103 while WAIT on pc 8 → opcode for 8 never appears; next out_pc=100; queue empty one cycle after redirect.
- Redirect same cycle as completion and pop with 2 entries → out_valid=0 next cycle, next fetch ip=redirect_pc.
- redirect_pc=32'hFFFF_FFF8 → out_pc FFFFFFF8, FFFFFFFC, 00000000.
- Assert reset during WAIT → all outputs at reset values immediately, fetch restarts at RESET_PC.
